// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module  : divider_pkg
// Purpose : Shared definitions for the restoring divider: default operand
//           widths, FSM state encoding and bit-counter width helper.
// Revision: 1.0  initial release
// ============================================================================
package divider_pkg;

  localparam int DVD_W_DEF = 7;   // dividend / quotient width
  localparam int DVS_W_DEF = 4;   // divisor / remainder width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold DVD_W-1; a 1-bit dividend still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(DVD_W_DEF);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module  : div_step
// Purpose : One restoring-division step (combinational). Shifts the next
//           dividend bit into the running remainder, compares against the
//           divisor and subtracts when it fits.
// Ports   : rem_in   [DVS_W-1:0]  running remainder before this step
//           dvd_bit               next dividend bit (MSB first)
//           divisor  [DVS_W-1:0]  divisor (nonzero when used)
//           rem_out  [DVS_W-1:0]  running remainder after this step
//           q_bit                 quotient bit produced by this step
// Revision: 1.0  initial release
// ============================================================================
module div_step
  import divider_pkg::*;
#(
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic [DVS_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] rem_out,
  output logic             q_bit
);

  // One extra bit so the shifted remainder never wraps before the compare.
  logic [DVS_W:0] partial;
  logic [DVS_W:0] diff;

  assign partial = {rem_in, dvd_bit};
  assign diff    = partial - {1'b0, divisor};
  assign q_bit   = (partial >= {1'b0, divisor});

  // The selected value is always < divisor, so its top bit is zero and the
  // truncation is lossless.
  assign rem_out = DVS_W'(q_bit ? diff : partial);

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module  : divider
// Purpose : Sequential unsigned restoring divider, one quotient bit per clock.
//           Fixed latency of DVD_W cycles in CALC; divide-by-zero finishes
//           immediately with an all-ones quotient and dbz set.
// Ports   : clk                     rising-edge clock
//           rst_n                   asynchronous active-low reset
//           en                      start request, sampled only in IDLE
//           dividend  [DVD_W-1:0]   numerator, captured on start
//           divisor   [DVS_W-1:0]   denominator, captured on start
//           done                    one-cycle result-valid pulse
//           quotient  [DVD_W-1:0]   result, held until next start
//           remainder [DVS_W-1:0]   remainder, held until next start
//           dbz                     divide-by-zero flag for last operation
// Revision: 1.0  initial release
// ============================================================================
module divider
  import divider_pkg::*;
#(
  parameter int DVD_W = DVD_W_DEF,
  parameter int DVS_W = DVS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             dbz
);

  localparam int              CNT_W    = cnt_width(DVD_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DVD_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [DVD_W-1:0] dvd_op;
  logic [DVS_W-1:0] dvs_op;
  logic [DVD_W-1:0] quo_work;
  logic [DVS_W-1:0] rem_work;

  logic [DVS_W-1:0] step_rem;
  logic             step_q;
  logic [DVD_W-1:0] quo_nxt;

  // The counter doubles as the dividend bit index: it runs DVD_W-1 down to 0,
  // which walks the captured dividend MSB first.
  div_step #(
    .DVS_W (DVS_W)
  ) u_step (
    .rem_in  (rem_work),
    .dvd_bit (dvd_op[cnt]),
    .divisor (dvs_op),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign quo_nxt = DVD_W'({quo_work, step_q});
  assign done    = (state == ST_DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt = (divisor == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == '0) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand, working and result registers. Results are written only on the
  // edge that enters DONE, so partial values never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dvd_op    <= '0;
      dvs_op    <= '0;
      quo_work  <= '0;
      rem_work  <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            dvd_op   <= dividend;
            dvs_op   <= divisor;
            cnt      <= CNT_LOAD;
            quo_work <= '0;
            rem_work <= '0;
            dbz      <= 1'b0;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              dbz       <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          quo_work <= quo_nxt;
          rem_work <= step_rem;
          if (cnt == '0) begin
            quotient  <= quo_nxt;
            remainder <= step_rem;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_divider
// Purpose : Self-checking bench for divider. A cycle-level behavioural model
//           (plain / and % with an operation countdown) is compared against
//           the DUT outputs every cycle; directed cases pin literal results.
// Revision: 1.0  initial release
// ============================================================================
module tb_divider;

  localparam int DVD_W = 7;
  localparam int DVS_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [DVD_W-1:0] dividend = '0;
  logic [DVS_W-1:0] divisor = '0;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             dbz;

  int total = 0;
  int bad   = 0;

  divider #(
    .DVD_W (DVD_W),
    .DVS_W (DVS_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dividend  (dividend),
    .divisor   (divisor),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // An accepted start either finishes at once (divisor 0) or DVD_W edges later;
  // the edge after a done cycle is always spent returning to idle.
  logic             m_done = 1'b0;
  logic [DVD_W-1:0] m_q    = '0;
  logic [DVS_W-1:0] m_r    = '0;
  logic             m_dbz  = 1'b0;
  logic [DVD_W-1:0] m_pq   = '0;
  logic [DVS_W-1:0] m_pr   = '0;
  int               m_busy = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_busy <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_q    <= m_pq;
        m_r    <= m_pr;
        m_done <= 1'b1;
      end
    end else if (en) begin
      if (divisor == '0) begin
        m_q    <= '1;
        m_r    <= '0;
        m_dbz  <= 1'b1;
        m_done <= 1'b1;
      end else begin
        m_dbz  <= 1'b0;
        m_pq   <= DVD_W'(int'(dividend) / int'(divisor));
        m_pr   <= DVS_W'(int'(dividend) % int'(divisor));
        m_busy <= DVD_W;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("cyc_done", done, m_done);
    check("cyc_quotient", quotient, m_q);
    check("cyc_remainder", remainder, m_r);
    check("cyc_dbz", dbz, m_dbz);
  end

  // ---------------- directed helpers ----------------
  // Start one operation from IDLE, wait for done, check latency and results.
  // With noise set, en and operands are scrambled while the DUT is busy.
  task automatic run(input logic [DVD_W-1:0] a, input logic [DVS_W-1:0] b,
                     input int eq, input int er, input int edbz, input int elat,
                     input bit noise);
    int lat;
    lat = 0;
    dividend = a;
    divisor  = b;
    en       = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
      end else if (noise) begin
        en       = 1'($urandom);
        dividend = DVD_W'($urandom);
        divisor  = DVS_W'($urandom);
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
    check($sformatf("lat %0d/%0d", a, b), lat, elat);
    check($sformatf("quo %0d/%0d", a, b), quotient, eq);
    check($sformatf("rem %0d/%0d", a, b), remainder, er);
    check($sformatf("dbz %0d/%0d", a, b), dbz, edbz);
    if (b != '0) begin
      check($sformatf("identity %0d/%0d", a, b),
            32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check($sformatf("rem<div %0d/%0d", a, b), 32'(remainder < b), 32'd1);
    end
    @(negedge clk);
  endtask

  int d1, d2, ndone, idx, off;
  logic [DVD_W-1:0] ra;
  logic [DVS_W-1:0] rb;

  initial begin
    repeat (2) @(negedge clk);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset dbz", dbz, 0);
    rst_n = 1'b1;

    // Literal cases, first start right after reset release
    run(7'd100, 4'd7, 14, 2, 0, 8, 1'b0);
    run(7'd127, 4'd1, 127, 0, 0, 8, 1'b0);
    run(7'd5, 4'd9, 0, 5, 0, 8, 1'b0);
    run(7'd42, 4'd0, 127, 0, 1, 1, 1'b0);

    // Back-to-back with operands changed mid-operation
    d1 = 0;
    d2 = 0;
    dividend = 7'd15;
    divisor  = 4'd15;
    en       = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30 && d2 == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        dividend = 7'd3;
        divisor  = 4'd2;
      end
      if (done) begin
        if (d1 == 0) begin
          d1 = k;
          check("b2b first quo", quotient, 1);
          check("b2b first rem", remainder, 0);
        end else begin
          d2 = k;
          check("b2b second quo", quotient, 1);
          check("b2b second rem", remainder, 1);
        end
      end
    end
    en = 1'b0;
    check("b2b first done cycle", d1, 8);
    check("b2b second done cycle", d2, 17);
    @(negedge clk);

    // Reset in the middle of CALC after a dbz result is on the outputs
    run(7'd42, 4'd0, 127, 0, 1, 1, 1'b0);
    dividend = 7'd100;
    divisor  = 4'd7;
    en       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no done after abort", ndone, 0);
    run(7'd9, 4'd4, 2, 1, 0, 8, 1'b0);

    // Every operand pair in a random order, with noise while busy
    off = int'($urandom_range(0, 2047));
    for (int i = 0; i < 2048; i++) begin
      idx = (i * 1237 + off) % 2048;
      ra  = DVD_W'(idx / 16);
      rb  = DVS_W'(idx % 16);
      if (rb == '0) begin
        run(ra, rb, 127, 0, 1, 1, 1'b1);
      end else begin
        run(ra, rb, int'(ra) / int'(rb), int'(ra) % int'(rb), 0, 8, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
